arp_note_scheduler: RTL and testbench
=====================================

// Module: arp_note_scheduler
// PURPOSE
// - Sequences the sine-table audio datapath: it generates the BRAM read address and a one-cycle step strobe at the current note rate.
// - Runs the base-note / arpeggio state machine and the per-note timer.
// - Sits between the button debouncer and the sine BRAM; the PWM stage consumes the BRAM output.
// PARAMETERS
// - NOTE_TICKS   50_000_000  clock cycles per arpeggio note (500 ms at 100 MHz)
// - ADDR_W       8           sine BRAM address width (256-entry table)
// - DIV_W        13          step divider counter width
// - BASE_OFFSET  746         added to sw to form f_base
// - DEFAULT_DIV  1493        divider used in BASE state (middle C)
// PORTS
// - CLK100MHZ     in   1       system clock, 100 MHz
// - RST           in   1       asynchronous, active-high reset
// - sw            in   8       base-note offset from the slide switches
// - arp_toggle    in   1       debounced button level; each rising edge toggles the mode
// - addr_o        out  ADDR_W  sine BRAM read address
// - step_o        out  1       one-cycle pulse, asserted in the cycle addr_o advances
// - note_o        out  3       current note: 0-3 in arpeggio, 4 in BASE; drives the LEDs
// - arp_active_o  out  1       1 while in ARP state
// BEHAVIOUR
// - Clocking: one clock. RST is asynchronous and active-high.
// - Reset values: addr_o=0, step_o=0, note_o=4, arp_active_o=0. Internal step counter, note timer, toggle-edge flop and direction flag are all 0.
// - Edge detect: a registered copy of arp_toggle; rise = arp_toggle & ~prev. The level held high produces no further edges.
// - FSM, 2 states:
//   - BASE (note_o=4)
//   - ARP (note_o=0..3)
// - Transitions:
//   - BASE -> ARP on rise: note 0, timer 0.
//   - ARP -> BASE on rise: note 4, timer cleared.
// - Note timer (ARP only):
//   - Increments every cycle.
//   - At NOTE_TICKS-1: timer <= 0 and the note advances.
//   - Default order: 0,1,2,3,0,...
// - Simultaneous rise and timer expiry: the rise wins. The timer is ignored that cycle.
// - f_base = BASE_OFFSET + sw, computed 10 bits wide. Range 746..1001; no truncation.
// - Divider, by note (integer floor, 11-bit result):
//   - note 0: 2*f_base
//   - note 1: (5*f_base)>>2
//   - note 2: (3*f_base)>>1
//   - note 3: f_base
//   - note 4: DEFAULT_DIV
// - The divider is registered: it is valid 1 cycle after sw or note changes.
// - Step counter increments every cycle.
//   - When cnt >= div-1: cnt <= 0, step_o <= 1, addr_o <= addr_o+1.
//   - Step period is exactly div cycles.
//   - Using >= makes a shrinking divider take effect immediately, with no 2^DIV_W wrap.
// - addr_o wraps 255 -> 0 silently. A mode change does not reset addr_o (phase continuous).
// - Reset mid-note: every register returns to its reset value immediately; no step pulse is emitted.
// - Downstream timing: the BRAM read latency is 1 cycle. The consumer samples douta one cycle after step_o.
// CONFIGURATION
// - Macro ARP_PINGPONG_EN.
//   - Defined: order 0,1,2,3,2,1,0,1,... The direction flag flips at notes 3 and 0 and is reset to "up" on BASE -> ARP.
//   - Undefined: ascending wrap 0,1,2,3,0. The direction flag is not synthesised.
// STRUCTURE
// - Package arp_pkg holds:
//   - note constants: NOTE_ROOT=0, NOTE_THIRD=1, NOTE_FIFTH=2, NOTE_OCT=3, NOTE_BASE=4
//   - state encoding: ST_BASE, ST_ARP
//   - BASE_OFFSET and DEFAULT_DIV defaults
// - Sub-module note_div_calc: a combinational map (note, f_base) -> divider. The parent registers its output.
// - The FSM, note timer, edge detect and step counter stay in this module.
// TESTING (bench overrides NOTE_TICKS=16)
// - Reset, sw=0: note_o=4, first step_o after 1493 cycles, then every 1493 cycles; addr_o counts 1,2,3.
// - Toggle rise, sw=0: arp_active_o=1, note_o=0. Step periods 1492, then 932, 1119, 746 per note, each note lasting 16 cycles.
// - sw=255 in ARP, note 0: period 2002. Switch sw to 0 mid-period with cnt>1491: a step fires on the next cycle, no wrap.
// - Rise in the same cycle as timer expiry in ARP: state goes to BASE, note_o=4, no note advance.
// - addr_o=255 at a step: addr_o=0. Assert RST mid-note: all outputs take reset values in the same cycle.
// - With ARP_PINGPONG_EN: note_o sequence over 8 notes is 0,1,2,3,2,1,0,1. Without it: 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/arp_pkg.sv
// ---------------------------------------------------------------------------
// arp_pkg
// Shared definitions for the arpeggio note scheduler:
//   - note codes used on note_o and by the divider map
//   - FSM state encoding (base note vs. running arpeggio)
//   - default tuning constants (base offset and middle-C divider)
// No ports; imported with "import arp_pkg::*".
// ---------------------------------------------------------------------------
package arp_pkg;

   // Note codes: the four arpeggio degrees plus the plain base note.
   localparam logic [2:0] NOTE_ROOT  = 3'd0;
   localparam logic [2:0] NOTE_THIRD = 3'd1;
   localparam logic [2:0] NOTE_FIFTH = 3'd2;
   localparam logic [2:0] NOTE_OCT   = 3'd3;
   localparam logic [2:0] NOTE_BASE  = 3'd4;

   // Two-state mode machine.
   typedef enum logic {
      ST_BASE = 1'b0,
      ST_ARP  = 1'b1
   } arp_state_t;

   // Tuning defaults: f_base = offset + sw, and the divider used in BASE.
   localparam int ARP_BASE_OFFSET = 746;
   localparam int ARP_DEFAULT_DIV = 1493;

endpackage

// File: rtl/note_div_calc.sv
// ---------------------------------------------------------------------------
// note_div_calc
// Purely combinational map from (current note, f_base) to the step divider
// that sets the sine-table playback rate. The parent registers the result.
//
// Ports:
//   note    in   3   current note code (0-3 arpeggio degrees, 4 = base note)
//   f_base  in  10   base divider, BASE_OFFSET + sw (746..1001)
//   div     out 11   step divider in clock cycles (integer floor)
//
// Parameters:
//   DEFAULT_DIV  divider returned for the base note (and unused codes)
// ---------------------------------------------------------------------------
module note_div_calc
   import arp_pkg::*;
#(
   parameter int DEFAULT_DIV = ARP_DEFAULT_DIV
) (
   input  logic [2:0]  note,
   input  logic [9:0]  f_base,
   output logic [10:0] div
);

   logic [12:0] f_wide;

   // The x5 and x3 products need up to 13 bits before the shift brings them
   // back into range, so the math is done on a widened copy of f_base.
   // A larger divider means a slower step rate, i.e. a lower pitch.
   always_comb begin
      f_wide = {3'b000, f_base};
      div    = 11'(DEFAULT_DIV);
      case (note)
         NOTE_ROOT:  div = {f_base, 1'b0};
         NOTE_THIRD: div = 11'((f_wide * 13'd5) >> 2);
         NOTE_FIFTH: div = 11'((f_wide * 13'd3) >> 1);
         NOTE_OCT:   div = {1'b0, f_base};
         default:    div = 11'(DEFAULT_DIV);
      endcase
   end

endmodule

// File: rtl/arp_note_scheduler.sv
// ---------------------------------------------------------------------------
// arp_note_scheduler
// Sequences the sine-table audio datapath. It toggles between a fixed base
// note and a four-note arpeggio on each rising edge of the debounced button,
// times each arpeggio note, and produces the sine BRAM read address together
// with a one-cycle step strobe at the current note rate.
//
// Ports:
//   CLK100MHZ     in   1       system clock, 100 MHz
//   RST           in   1       asynchronous, active-high reset
//   sw            in   8       base-note offset from the slide switches
//   arp_toggle    in   1       debounced button level; rising edge toggles mode
//   addr_o        out  ADDR_W  sine BRAM read address
//   step_o        out  1       one-cycle pulse in the cycle addr_o advances
//   note_o        out  3       current note: 0-3 in arpeggio, 4 in BASE
//   arp_active_o  out  1       high while the arpeggio runs
//
// Build option:
//   ARP_PINGPONG_EN  when defined the arpeggio bounces 0,1,2,3,2,1,0,1,...
//                    otherwise it wraps 0,1,2,3,0,...
// ---------------------------------------------------------------------------
module arp_note_scheduler
   import arp_pkg::*;
#(
   parameter int NOTE_TICKS  = 50_000_000,
   parameter int ADDR_W      = 8,
   parameter int DIV_W       = 13,
   parameter int BASE_OFFSET = ARP_BASE_OFFSET,
   parameter int DEFAULT_DIV = ARP_DEFAULT_DIV
) (
   input  logic              CLK100MHZ,
   input  logic              RST,
   input  logic [7:0]        sw,
   input  logic              arp_toggle,
   output logic [ADDR_W-1:0] addr_o,
   output logic              step_o,
   output logic [2:0]        note_o,
   output logic              arp_active_o
);

   localparam int TIMER_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(NOTE_TICKS - 1);

   arp_state_t         state;
   logic               toggle_prev;
   logic               rise;
   logic [TIMER_W-1:0] timer;
   logic [9:0]         f_base;
   logic [10:0]        div_next;
   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   cnt;
`ifdef ARP_PINGPONG_EN
   logic               dir_down;
`endif

   // The button level is already debounced; only its rising edge matters,
   // so holding the button does not keep flipping the mode.
   assign rise = arp_toggle & ~toggle_prev;

   // 746 + 255 = 1001 still fits in 10 bits, so nothing is lost here.
   assign f_base = 10'(BASE_OFFSET) + {2'b00, sw};

   note_div_calc #(
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div_calc (
      .note   (note_o),
      .f_base (f_base),
      .div    (div_next)
   );

   // Registered copy of the button level for edge detection.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         toggle_prev <= 1'b0;
      end else begin
         toggle_prev <= arp_toggle;
      end
   end

   // Mode FSM plus the per-note timer. A button edge always takes priority
   // over a timer expiry landing in the same cycle, so leaving the arpeggio
   // never also advances the note. Entering the arpeggio restarts it at the
   // root with a fresh timer and an upward direction.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         state        <= ST_BASE;
         note_o       <= NOTE_BASE;
         arp_active_o <= 1'b0;
         timer        <= '0;
`ifdef ARP_PINGPONG_EN
         dir_down     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_BASE: begin
               if (rise) begin
                  state        <= ST_ARP;
                  note_o       <= NOTE_ROOT;
                  arp_active_o <= 1'b1;
                  timer        <= '0;
`ifdef ARP_PINGPONG_EN
                  dir_down     <= 1'b0;
`endif
               end
            end
            ST_ARP: begin
               if (rise) begin
                  state        <= ST_BASE;
                  note_o       <= NOTE_BASE;
                  arp_active_o <= 1'b0;
                  timer        <= '0;
               end else if (timer == TIMER_LAST) begin
                  timer <= '0;
`ifdef ARP_PINGPONG_EN
                  if (!dir_down) begin
                     if (note_o == NOTE_OCT) begin
                        note_o   <= NOTE_FIFTH;
                        dir_down <= 1'b1;
                     end else begin
                        note_o <= note_o + 3'd1;
                     end
                  end else begin
                     if (note_o == NOTE_ROOT) begin
                        note_o   <= NOTE_THIRD;
                        dir_down <= 1'b0;
                     end else begin
                        note_o <= note_o - 3'd1;
                     end
                  end
`else
                  note_o <= (note_o == NOTE_OCT) ? NOTE_ROOT : note_o + 3'd1;
`endif
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            default: begin
               state        <= ST_BASE;
               note_o       <= NOTE_BASE;
               arp_active_o <= 1'b0;
               timer        <= '0;
            end
         endcase
      end
   end

   // Divider register and step counter. The counter restarts once it reaches
   // div-1, giving a step period of exactly div cycles. The >= compare means
   // that when the divider shrinks below the running count, the step fires
   // on the next cycle instead of the counter running all the way round.
   // The address keeps running across mode changes so the waveform phase
   // stays continuous; it wraps silently at the top of the table.
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         div_q  <= DIV_W'(DEFAULT_DIV);
         cnt    <= '0;
         step_o <= 1'b0;
         addr_o <= '0;
      end else begin
         div_q <= DIV_W'(div_next);
         if (cnt >= div_q - DIV_W'(1)) begin
            cnt    <= '0;
            step_o <= 1'b1;
            addr_o <= addr_o + ADDR_W'(1);
         end else begin
            cnt    <= cnt + DIV_W'(1);
            step_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arp_note_scheduler.sv
// ---------------------------------------------------------------------------
// tb_arp_note_scheduler
// Self-checking bench for arp_note_scheduler. Instance A uses 16-cycle notes
// for the note sequence, edge/expiry priority and mid-note reset. Instance B
// uses long notes and a tiny base divider so step periods inside each note
// and the address wrap can be observed in a short run.
// ---------------------------------------------------------------------------
module tb_arp_note_scheduler;

   logic       CLK100MHZ = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] sw_a, sw_b;
   logic       tog_a, tog_b;
   logic [7:0] addr_a, addr_b;
   logic       step_a, step_b;
   logic [2:0] note_a, note_b;
   logic       active_a, active_b;

   int total = 0;
   int bad = 0;

   int         q_period[$];
   logic [7:0] q_addr[$];
   logic [2:0] q_note[$];

   arp_note_scheduler #(
      .NOTE_TICKS (16)
   ) dut_a (
      .CLK100MHZ    (CLK100MHZ),
      .RST          (RST),
      .sw           (sw_a),
      .arp_toggle   (tog_a),
      .addr_o       (addr_a),
      .step_o       (step_a),
      .note_o       (note_a),
      .arp_active_o (active_a)
   );

   arp_note_scheduler #(
      .NOTE_TICKS  (8000),
      .DEFAULT_DIV (4)
   ) dut_b (
      .CLK100MHZ    (CLK100MHZ),
      .RST          (RST),
      .sw           (sw_b),
      .arp_toggle   (tog_b),
      .addr_o       (addr_b),
      .step_o       (step_b),
      .note_o       (note_b),
      .arp_active_o (active_b)
   );

   // 100 MHz clock.
   always #5 CLK100MHZ = ~CLK100MHZ;

   // Hard stop in case something never finishes.
   initial begin
      #800_000;
      $display("[TB] FAIL watchdog: observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input bit which, input logic [7:0] sw_val, input logic tog);
      if (which) begin
         sw_b  = sw_val;
         tog_b = tog;
      end else begin
         sw_a  = sw_val;
         tog_a = tog;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Counts clock edges until the chosen instance shows a step, bounded.
   task automatic waitStep(input bit which, input int limit, output int cycles);
      cycles = 0;
      do begin
         @(posedge CLK100MHZ);
         #1;
         cycles++;
      end while (((which ? step_b : step_a) !== 1'b1) && (cycles <= limit));
   endtask

   // Directed sequence: instance A tests first, then instance B.
   initial begin
      int c;
      logic [7:0] addr_save;

      applyStimulus(0, 8'd0, 1'b0);
      applyStimulus(1, 8'd0, 1'b0);
      #2 RST = 1'b1;
      #10;
      $display("[TB] reset values");
      checkOutput("a_rst_addr", addr_a, 0);
      checkOutput("a_rst_step", step_a, 0);
      checkOutput("a_rst_note", note_a, 4);
      checkOutput("a_rst_active", active_a, 0);
      @(negedge CLK100MHZ);
      RST = 1'b0;

      // BASE note, sw=0: middle-C divider, address counting up.
      $display("[TB] base note periods");
      for (int k = 1; k <= 3; k++) begin
         q_period.push_back(1493);
         q_addr.push_back(8'(k));
      end
      for (int k = 0; k < 3; k++) begin
         waitStep(0, 2000, c);
         checkOutput("a_base_period", c, q_period.pop_front());
         checkOutput("a_base_addr", addr_a, q_addr.pop_front());
      end

      // Enter the arpeggio and follow eight notes of 16 cycles each.
      $display("[TB] arpeggio note order");
`ifdef ARP_PINGPONG_EN
      foreach (q_note[i]) q_note.delete(i);
      q_note = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
`else
      q_note = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
`endif
      applyStimulus(0, 8'd0, 1'b1);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("a_arp_active", active_a, 1);
      checkOutput("a_arp_note", note_a, q_note.pop_front());
      applyStimulus(0, 8'd0, 1'b0);
      for (int k = 1; k < 8; k++) begin
         repeat (16) @(posedge CLK100MHZ);
         #1;
         checkOutput("a_arp_note", note_a, q_note.pop_front());
      end

      // Rise lands on the same edge as the timer expiry: leave to BASE.
      $display("[TB] rise at timer expiry");
      repeat (15) @(posedge CLK100MHZ);
      #1;
      applyStimulus(0, 8'd0, 1'b1);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("a_collide_note", note_a, 4);
      checkOutput("a_collide_active", active_a, 0);

      // Reset in the middle of an arpeggio note.
      $display("[TB] reset mid-note");
      applyStimulus(0, 8'd0, 1'b0);
      @(posedge CLK100MHZ);
      #1;
      applyStimulus(0, 8'd0, 1'b1);
      @(posedge CLK100MHZ);
      repeat (5) @(posedge CLK100MHZ);
      #1;
      checkOutput("a_pre_rst_note", note_a, 0);
      checkOutput("a_pre_rst_active", active_a, 1);
      #2 RST = 1'b1;
      #1;
      checkOutput("a_midrst_addr", addr_a, 0);
      checkOutput("a_midrst_step", step_a, 0);
      checkOutput("a_midrst_note", note_a, 4);
      checkOutput("a_midrst_active", active_a, 0);
      checkOutput("b_midrst_addr", addr_b, 0);
      applyStimulus(0, 8'd0, 1'b0);
      applyStimulus(1, 8'd0, 1'b0);
      @(negedge CLK100MHZ);
      RST = 1'b0;

      // Instance B in BASE with divider 4: walk the address through a wrap.
      $display("[TB] address wrap");
      for (int k = 1; k <= 257; k++) q_addr.push_back(8'(k));
      for (int k = 1; k <= 257; k++) begin
         waitStep(1, 100, c);
         checkOutput("b_base_period", c, 4);
         checkOutput("b_addr_wrap", addr_b, q_addr.pop_front());
      end

      // Arpeggio step periods with sw=0.
      $display("[TB] arpeggio periods sw=0");
      q_period.push_back(1492);
      q_period.push_back(932);
      q_period.push_back(1119);
      q_period.push_back(746);
      applyStimulus(1, 8'd0, 1'b1);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("b_arp_active", active_b, 1);
      checkOutput("b_arp_note", note_b, 0);
      applyStimulus(1, 8'd0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         c = 0;
         while ((note_b !== 3'(n)) && (c < 9000)) begin
            @(posedge CLK100MHZ);
            #1;
            c++;
         end
         checkOutput("b_note_reach", note_b, n);
         waitStep(1, 3000, c);
         waitStep(1, 3000, c);
         checkOutput("b_arp_period", c, q_period.pop_front());
      end

      // Back to BASE, then re-enter the arpeggio with sw=255.
      $display("[TB] sw=255 and shrinking divider");
      applyStimulus(1, 8'd255, 1'b1);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("b_back_base_note", note_b, 4);
      checkOutput("b_back_base_active", active_b, 0);
      applyStimulus(1, 8'd255, 1'b0);
      @(posedge CLK100MHZ);
      #1;
      applyStimulus(1, 8'd255, 1'b1);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("b_reenter_note", note_b, 0);
      q_period.push_back(2002);
      waitStep(1, 3000, c);
      waitStep(1, 3000, c);
      checkOutput("b_sw255_period", c, q_period.pop_front());

      // Counter is now at 1600; dropping sw makes the divider 1492.
      repeat (1600) @(posedge CLK100MHZ);
      #1;
      addr_save = addr_b;
      applyStimulus(1, 8'd0, 1'b0);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("b_shrink_wait", step_b, 0);
      @(posedge CLK100MHZ);
      #1;
      checkOutput("b_shrink_step", step_b, 1);
      checkOutput("b_shrink_addr", addr_b, 8'(addr_save + 8'd1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
